spi_regfile_slave: RTL and testbench

SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

---
 rtl/spi_regfile_pkg.sv | 16 +
 rtl/spi_regfile_slave_if.sv | 23 ++
 rtl/spi_byte_slave.sv | 88 ++++++++
 rtl/spi_regfile_slave.sv | 138 +++++++++++++
 tb/tb_spi_regfile_slave.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file slave.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StDataWr,
    StDataRd,
    StWaitCsHigh
  } state_e;

  localparam int unsigned CMD_RW_BIT          = 7;
  localparam int unsigned ADDR_FIELD_W        = 7;
  localparam logic [7:0]  STATUS_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_regfile_slave_if.sv
// SPI wire bundle between an SPI master and the register-file slave.
interface spi_regfile_slave_if;

  logic spi_clk;
  logic spi_mosi;
  logic spi_cs_n;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_mosi,
    output spi_cs_n,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_mosi,
    input  spi_cs_n,
    output spi_miso
  );

endinterface

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte engine: input synchronisers, edge detect, rx/tx shift registers and bit counter.
module spi_byte_slave (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       sck_en,
  input  logic       load_tx,
  input  logic [7:0] tx_data,
  output logic       spi_miso,
  output logic       cs_sync,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  // Bit 0: first sync stage, bit 1: synchronised level, bit 2: previous synchronised level.
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       byte_done_q, byte_done_d;

  logic sck_rise, sck_fall, done_now;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_sync  = cs_q[1];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign done_now = sck_en & sck_rise & (bit_cnt_q == 3'd7);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    byte_done_d = done_now;
    if (sck_en && sck_rise) begin
      rx_d      = {rx_q[6:0], mosi_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The falling edge that closes a byte keeps the freshly loaded MSB in place.
    if (sck_en && sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
    if (load_tx) begin
      tx_d = tx_data;
    end
    // A byte finishing together with deselect is still handed to the parent.
    if (cs_rise) begin
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
      if (!done_now) begin
        rx_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sck_q       <= 3'b000;
      cs_q        <= 3'b111;
      mosi_q      <= 2'b00;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      byte_done_q <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], spi_clk};
      cs_q        <= {cs_q[1:0], spi_cs_n};
      mosi_q      <= {mosi_q[0], spi_mosi};
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign spi_miso  = tx_q[7];
  assign byte_done = byte_done_q;
  assign rx_byte   = rx_q;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI-addressed register bank: command decode FSM, auto-incrementing pointer and register storage.
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_l,
  spi_regfile_slave_if.slave          spi,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  state_e         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           wr_mode_q, wr_mode_d;
  logic [1:0]     settle_q, settle_d;
  logic [7:0]     regs_q [NUM_REGS];

  logic           sck_en, load_tx, cs_sync, cs_fall, cs_rise, byte_done;
  logic [7:0]     tx_data, rx_byte;
  logic [AW-1:0]  cmd_addr;

  spi_byte_slave u_byte (
    .clk       (clk),
    .rst_l     (rst_l),
    .spi_clk   (spi.spi_clk),
    .spi_mosi  (spi.spi_mosi),
    .spi_cs_n  (spi.spi_cs_n),
    .sck_en    (sck_en),
    .load_tx   (load_tx),
    .tx_data   (tx_data),
    .spi_miso  (spi.spi_miso),
    .cs_sync   (cs_sync),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  assign sck_en   = (state_q == StCmd) || (state_q == StDataWr) || (state_q == StDataRd);
  assign cmd_addr = AW'(rx_byte[ADDR_FIELD_W-1:0]);
  // wr_mode_q outlives a deselect so a byte completing with cs_n rising still commits.
  assign wr_stb   = byte_done & wr_mode_q;
  assign wr_addr  = wr_stb ? ptr_q : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_mode_d = wr_mode_q;
    load_tx   = 1'b0;
    tx_data   = 8'h00;
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    if (wr_stb) begin
      ptr_d = ptr_q + AW'(1);
    end
    unique case (state_q)
      StIdle: begin
        // Until the synchronisers have filled, a low cs_n means it was low across reset.
        if (settle_q != 2'd3) begin
          if (!cs_sync) begin
            state_d = StWaitCsHigh;
          end
        end else if (cs_fall) begin
          state_d   = StCmd;
          load_tx   = 1'b1;
          tx_data   = STATUS_BYTE;
          wr_mode_d = 1'b0;
        end
      end
      StCmd: begin
        if (byte_done) begin
          load_tx = 1'b1;
          if (rx_byte[CMD_RW_BIT]) begin
            state_d = StDataRd;
            tx_data = regs_q[cmd_addr];
            ptr_d   = cmd_addr + AW'(1);
          end else begin
            state_d   = StDataWr;
            ptr_d     = cmd_addr;
            wr_mode_d = 1'b1;
          end
        end
      end
      StDataRd: begin
        if (byte_done) begin
          load_tx = 1'b1;
          tx_data = regs_q[ptr_q];
          ptr_d   = ptr_q + AW'(1);
        end
      end
      StDataWr: begin
      end
      StWaitCsHigh: begin
        if (cs_sync) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (cs_rise) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      wr_mode_q <= 1'b0;
      settle_q  <= 2'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_mode_q <= wr_mode_d;
      settle_q  <= settle_d;
      if (wr_stb) begin
        regs_q[ptr_q] <= rx_byte;
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[8*k +: 8] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench for spi_regfile_slave: vector table, corner-case sequences and a modelled soak.
module tb_spi_regfile_slave;

  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [63:0]   regs_o;
  logic          wr_stb;
  logic [2:0]    wr_addr;

  spi_regfile_slave_if spi_if ();

  spi_regfile_slave #(
    .NUM_REGS    (NR),
    .RESET_VAL   (8'h00),
    .STATUS_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_l   (rst_l),
    .spi     (spi_if.slave),
    .regs_o  (regs_o),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr)
  );

  always #5 clk = ~clk;

  logic [2:0] wr_log [$];
  always @(negedge clk) if (wr_stb) wr_log.push_back(wr_addr);

  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  nd;
    logic [23:0] d;
    logic [23:0] exp_rd;
    logic [8:0]  exp_wa;
  } vec_t;

  int         n_checks = 0;
  int         n_errs   = 0;
  logic [7:0] mdl    [NR];
  logic [7:0] rx_buf [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mdl_flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  // Mode-0 master: MOSI changes with SCK low, MISO sampled just before each rising edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = spi_if.spi_miso;
      spi_if.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.spi_clk = 1'b0;
    end
  endtask

  task automatic txn(input logic [7:0] cmd, input int nd, input logic [23:0] d,
                     input int setup, input int hold);
    logic [7:0]  b, r;
    logic [23:0] dd;
    dd = d;
    spi_if.spi_cs_n = 1'b0;
    repeat (setup) @(negedge clk);
    spi_xfer(cmd, 8, r);
    rx_buf[0] = r;
    for (int k = 0; k < nd; k++) begin
      b = dd[23:16];
      dd = dd << 8;
      spi_xfer(b, 8, r);
      rx_buf[k+1] = r;
    end
    repeat (hold) @(negedge clk);
    spi_if.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    vec_t        vecs [8];
    vec_t        v;
    logic [23:0] t;
    logic [8:0]  wa;
    logic [7:0]  r, cmd, exp_b;
    logic [2:0]  a;
    logic [23:0] rd;
    int          base, nd;

    vecs[0] = '{8'h02, 2'd3, 24'h112233, 24'h000000, 9'b010_011_100};
    vecs[1] = '{8'h82, 2'd3, 24'h000000, 24'h112233, 9'b000_000_000};
    vecs[2] = '{8'h0B, 2'd1, 24'h5A0000, 24'h000000, 9'b011_000_000};
    vecs[3] = '{8'h07, 2'd2, 24'h778800, 24'h000000, 9'b111_000_000};
    vecs[4] = '{8'h87, 2'd2, 24'h000000, 24'h778800, 9'b000_000_000};
    vecs[5] = '{8'h83, 2'd1, 24'h000000, 24'h5A0000, 9'b000_000_000};
    vecs[6] = '{8'hFF, 2'd1, 24'h000000, 24'h770000, 9'b000_000_000};
    vecs[7] = '{8'h80, 2'd3, 24'h000000, 24'h880011, 9'b000_000_000};

    spi_if.spi_clk  = 1'b0;
    spi_if.spi_mosi = 1'b0;
    spi_if.spi_cs_n = 1'b1;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;

    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset regs", regs_o, 64'h0);
    chk("reset wr_stb", 64'(wr_stb), 64'h0);
    chk("reset wr_addr", 64'(wr_addr), 64'h0);
    chk("reset miso", 64'(spi_if.spi_miso), 64'h0);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      v    = vecs[i];
      base = wr_log.size();
      txn(v.cmd, int'(v.nd), v.d, 3, 2);
      chk("vec status", 64'(rx_buf[0]), 64'hA5);
      if (v.cmd[7]) begin
        t = v.exp_rd;
        for (int j = 0; j < int'(v.nd); j++) begin
          chk("vec read", 64'(rx_buf[j+1]), 64'(t[23:16]));
          t = t << 8;
        end
        chk("vec read no wr_stb", 64'(wr_log.size() - base), 64'h0);
      end else begin
        chk("vec wr count", 64'(wr_log.size() - base), 64'(v.nd));
        wa = v.exp_wa;
        t  = v.d;
        a  = v.cmd[2:0];
        for (int j = 0; j < int'(v.nd); j++) begin
          if (base + j < wr_log.size()) chk("vec wr_addr", 64'(wr_log[base+j]), 64'(wa[8:6]));
          wa = wa << 3;
          mdl[a] = t[23:16];
          t = t << 8;
          a = a + 3'd1;
        end
      end
      chk("vec regs", regs_o, mdl_flat());
    end

    // Abort after 5 data bits: nothing written, next transaction decodes normally
    base = wr_log.size();
    spi_if.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    spi_xfer(8'h01, 8, r);
    spi_xfer(8'hFF, 5, r);
    repeat (2) @(negedge clk);
    spi_if.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort no wr_stb", 64'(wr_log.size() - base), 64'h0);
    chk("abort regs", regs_o, mdl_flat());
    chk("abort miso idle", 64'(spi_if.spi_miso), 64'h0);
    txn(8'h81, 1, 24'h0, 2, 2);
    chk("post-abort status", 64'(rx_buf[0]), 64'hA5);
    chk("post-abort read reg1", 64'(rx_buf[1]), 64'h00);
    txn(8'h01, 1, 24'h3C0000, 2, 2);
    mdl[1] = 8'h3C;
    chk("post-abort write", regs_o, mdl_flat());

    // cs_n rises right after the 8th SCK rise of a data byte: byte still commits
    base = wr_log.size();
    spi_if.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    spi_xfer(8'h06, 8, r);
    spi_xfer(8'hE7, 7, r);
    spi_if.spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_clk = 1'b1;
    @(negedge clk);
    spi_if.spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    mdl[6] = 8'hE7;
    chk("late cs commit count", 64'(wr_log.size() - base), 64'h1);
    if (wr_log.size() > base) chk("late cs commit addr", 64'(wr_log[base]), 64'h6);
    chk("late cs commit regs", regs_o, mdl_flat());

    // Reset during a write with cs_n held low across reset release
    spi_if.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    spi_xfer(8'h04, 8, r);
    spi_xfer(8'hAA, 4, r);
    rst_l = 1'b0;
    @(negedge clk);
    chk("mid reset regs", regs_o, 64'h0);
    chk("mid reset wr_stb", 64'(wr_stb), 64'h0);
    chk("mid reset miso", 64'(spi_if.spi_miso), 64'h0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    repeat (6) @(negedge clk);
    base = wr_log.size();
    spi_xfer(8'h00, 8, r);
    spi_xfer(8'hFF, 8, r);
    chk("wait-cs miso silent", 64'(r), 64'h00);
    spi_if.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("wait-cs no wr_stb", 64'(wr_log.size() - base), 64'h0);
    chk("wait-cs regs", regs_o, 64'h0);
    txn(8'h04, 1, 24'hC30000, 2, 2);
    mdl[4] = 8'hC3;
    txn(8'h84, 1, 24'h0, 2, 2);
    chk("post-reset status", 64'(rx_buf[0]), 64'hA5);
    chk("post-reset readback", 64'(rx_buf[1]), 64'hC3);
    chk("post-reset regs", regs_o, mdl_flat());

    // Modelled soak at SCK = clk/8 with random cs_n setup and hold
    for (int n = 0; n < 350; n++) begin
      cmd  = 8'($urandom());
      nd   = int'($urandom_range(1, 2));
      rd   = 24'($urandom());
      base = wr_log.size();
      txn(cmd, nd, rd, int'($urandom_range(0, 4)), int'($urandom_range(1, 6)));
      chk("soak status", 64'(rx_buf[0]), 64'hA5);
      a = cmd[2:0];
      t = rd;
      if (cmd[7]) begin
        for (int j = 0; j < nd; j++) begin
          exp_b = mdl[a];
          chk("soak read", 64'(rx_buf[j+1]), 64'(exp_b));
          a = a + 3'd1;
        end
        chk("soak read no wr_stb", 64'(wr_log.size() - base), 64'h0);
      end else begin
        chk("soak wr count", 64'(wr_log.size() - base), 64'(nd));
        for (int j = 0; j < nd; j++) begin
          if (base + j < wr_log.size()) chk("soak wr_addr", 64'(wr_log[base+j]), 64'(a));
          mdl[a] = t[23:16];
          t = t << 8;
          a = a + 3'd1;
        end
      end
      chk("soak regs", regs_o, mdl_flat());
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
